// File: rtl/readout_channel_scheduler_pkg.sv
// Shared widths, FSM state encodings and the channel-index width helper
// for readout_channel_scheduler.
package readout_sched_pkg;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned DATA_W = 120;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned IDLE_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GRANT = 2'd1;
  localparam state_t ST_BURST = 2'd2;
  localparam state_t ST_GAP   = 2'd3;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/readout_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter
  import readout_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);
  logic [IDX_W-1:0] c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      c = IDX_W'((32'(ptr) + k) % NUM_CH);
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end
endmodule

// File: rtl/readout_channel_scheduler.sv
// Round-robin burst scheduler from FWFT channel FIFOs onto one valid/ready stream.
// Optional per-channel statistics outputs are built when SCHED_STATS_EN is defined.
module readout_channel_scheduler #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = readout_sched_pkg::CNT_W,
  parameter int unsigned DATA_W = readout_sched_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        channel_linked,
  input  logic [NUM_CH-1:0]        channel_fifo_empty,
  input  logic [NUM_CH*CNT_W-1:0]  channel_data_counter,
  input  logic [NUM_CH*DATA_W-1:0] channel_data,
  output logic [NUM_CH-1:0]        channel_data_read,
  input  logic [11:0]              counter_th,
  input  logic [15:0]              idle_counter_number_th,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_first,
  output logic                     out_last,
  output logic [2:0]               out_channel,
  output logic                     busy
`ifdef SCHED_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]     stats_words,
  output logic [NUM_CH*16-1:0]     stats_timeout_grants
`endif
);
  import readout_sched_pkg::*;

  localparam int unsigned IDX_W = ch_idx_w(NUM_CH);

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  cur_ch;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  pop_ch;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] count_ok;
  logic [NUM_CH-1:0] gnt_oh;
  logic [NUM_CH-1:0] serving;
  logic              gnt_vld;
  logic [LEN_W-1:0]  th_eff;
  logic [LEN_W-1:0]  len_left;
  logic [LEN_W-1:0]  g_cnt;
  logic [LEN_W-1:0]  g_len;
  logic [IDLE_W-1:0] idle_cnt [NUM_CH];
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [DATA_W-1:0] head     [NUM_CH];
  logic              last_q;
  logic              abort;
  logic              accept;
  logic              do_grant;
  logic              do_pop;
  logic              pop;
  logic              burst_done;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt[i]  = channel_data_counter[i*CNT_W +: CNT_W];
      head[i] = channel_data[i*DATA_W +: DATA_W];
    end
  end

  assign th_eff = (counter_th == '0) ? LEN_W'(1) : LEN_W'(counter_th);

  always_comb begin
    count_ok = '0;
    elig     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      count_ok[i] = LEN_W'(cnt[i]) >= th_eff;
      elig[i]     = channel_linked[i] & ~channel_fifo_empty[i]
                    & (count_ok[i] | (idle_cnt[i] >= idle_counter_number_th));
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req   (elig),
    .ptr   (rr_ptr),
    .gnt   (gnt_oh),
    .idx   (gnt_idx),
    .valid (gnt_vld)
  );

  // The channel being served keeps its idle timer cleared from grant to GAP.
  always_comb begin
    serving = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      serving[i] = ((state == ST_GRANT) & gnt_oh[i])
                 | (((state == ST_BURST) | (state == ST_GAP)) & (cur_ch == IDX_W'(i)));
    end
  end

  always_comb begin
    g_cnt = LEN_W'(cnt[gnt_idx]);
    g_len = (g_cnt < th_eff) ? g_cnt : th_eff;
    if (g_len == '0) g_len = LEN_W'(1);
  end

  // First word is popped on the GRANT edge so data appears two cycles after eligibility.
  assign abort      = ~channel_linked[cur_ch] | channel_fifo_empty[cur_ch];
  assign accept     = out_valid & out_ready;
  assign do_grant   = ~reset & (state == ST_GRANT) & gnt_vld;
  assign do_pop     = ~reset & (state == ST_BURST) & (len_left != '0) & ~abort
                      & (~out_valid | out_ready);
  assign pop        = do_grant | do_pop;
  assign pop_ch     = (state == ST_GRANT) ? gnt_idx : cur_ch;
  assign burst_done = (state == ST_BURST) & ((len_left == '0) | abort)
                      & (~out_valid | out_ready);

  assign channel_data_read = pop ? (NUM_CH'(1) << pop_ch) : '0;
  // A pending word is tagged last as soon as its channel drops out.
  assign out_last    = last_q | ((state == ST_BURST) & out_valid & abort);
  assign out_channel = 3'(cur_ch);
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      len_left  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        last_q    <= 1'b0;
      end
      if (pop) begin
        out_data  <= head[pop_ch];
        out_valid <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (enable && (elig != '0)) state <= ST_GRANT;
        end
        ST_GRANT: begin
          if (gnt_vld) begin
            cur_ch    <= gnt_idx;
            rr_ptr    <= (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            out_first <= 1'b1;
            last_q    <= (g_len == LEN_W'(1));
            len_left  <= g_len - LEN_W'(1);
            state     <= ST_BURST;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (do_pop) begin
            out_first <= 1'b0;
            last_q    <= (len_left == LEN_W'(1));
            len_left  <= len_left - LEN_W'(1);
          end else if (abort) begin
            len_left <= '0;
            if (out_valid && !out_ready) last_q <= 1'b1;
          end
          if (burst_done) state <= ST_GAP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (reset || !channel_linked[i] || channel_fifo_empty[i] || serving[i]) begin
        idle_cnt[i] <= '0;
      end else if (idle_cnt[i] != '1) begin
        idle_cnt[i] <= idle_cnt[i] + 1'b1;
      end
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        stats_words[i*32 +: 32]          <= '0;
        stats_timeout_grants[i*16 +: 16] <= '0;
      end else begin
        if (accept && (cur_ch == IDX_W'(i)) && (stats_words[i*32 +: 32] != '1))
          stats_words[i*32 +: 32] <= stats_words[i*32 +: 32] + 32'd1;
        if (do_grant && (gnt_idx == IDX_W'(i)) && !count_ok[i]
            && (stats_timeout_grants[i*16 +: 16] != '1))
          stats_timeout_grants[i*16 +: 16] <= stats_timeout_grants[i*16 +: 16] + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_readout_channel_scheduler.sv
// Directed self-checking bench for readout_channel_scheduler with a FWFT FIFO model.
module tb_readout_channel_scheduler;
  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [7:0]   channel_linked;
  logic [7:0]   channel_fifo_empty;
  logic [79:0]  channel_data_counter;
  logic [959:0] channel_data;
  logic [7:0]   channel_data_read;
  logic [11:0]  counter_th;
  logic [15:0]  idle_counter_number_th;
  logic [119:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_first;
  logic         out_last;
  logic [2:0]   out_channel;
  logic         busy;
`ifdef SCHED_STATS_EN
  logic [255:0] stats_words;
  logic [127:0] stats_timeout_grants;
`endif

  readout_channel_scheduler #(
    .NUM_CH (8),
    .CNT_W  (10),
    .DATA_W (120)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .channel_linked         (channel_linked),
    .channel_fifo_empty     (channel_fifo_empty),
    .channel_data_counter   (channel_data_counter),
    .channel_data           (channel_data),
    .channel_data_read      (channel_data_read),
    .counter_th             (counter_th),
    .idle_counter_number_th (idle_counter_number_th),
    .out_data               (out_data),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out_first              (out_first),
    .out_last               (out_last),
    .out_channel            (out_channel),
    .busy                   (busy)
`ifdef SCHED_STATS_EN
    ,
    .stats_words            (stats_words),
    .stats_timeout_grants   (stats_timeout_grants)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int bad_pop = 0;
  int fill [8];
  int head [8];
  int pop_cnt [8];
  bit ready_mode;
  bit stall_chk;
  logic [119:0] lg_data [$];
  bit           lg_first [$];
  bit           lg_last [$];
  int           lg_ch [$];
  int           lg_cyc [$];

  function automatic logic [119:0] word(input int ch, input int k);
    return {8'hC0 + 8'(ch), 80'h0, 8'(ch), 8'h00, 16'(k)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < 8; i++) begin
      channel_fifo_empty[i]             = (fill[i] == 0);
      channel_data_counter[i*10 +: 10]  = 10'(fill[i]);
      channel_data[i*120 +: 120]        = word(i, head[i]);
    end
  endtask

  task automatic step();
    logic [7:0]   rd;
    logic         stall;
    logic [119:0] pd;
    logic         pf;
    logic         pl;
    logic [2:0]   pc;
    rd = channel_data_read;
    for (int i = 0; i < 8; i++) if (rd[i] === 1'b1 && channel_fifo_empty[i]) bad_pop++;
    if (out_valid === 1'b1 && out_ready) begin
      lg_data.push_back(out_data);
      lg_first.push_back(out_first);
      lg_last.push_back(out_last);
      lg_ch.push_back(int'(out_channel));
      lg_cyc.push_back(cyc + 1);
    end
    stall = stall_chk && (out_valid === 1'b1) && !out_ready && !reset;
    pd = out_data; pf = out_first; pl = out_last; pc = out_channel;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (rd[i] === 1'b1) begin
        pop_cnt[i]++;
        head[i]++;
        if (fill[i] > 0) fill[i]--;
      end
    end
    if (ready_mode) out_ready = !out_ready;
    drive_fifos();
    #1;
    if (stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, pd);
      check("stall_first", out_first, pf);
      check("stall_last", out_last, pl);
      check("stall_channel", out_channel, pc);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    lg_data.delete(); lg_first.delete(); lg_last.delete(); lg_ch.delete(); lg_cyc.delete();
  endtask

  task automatic reset_dut();
    reset = 1'b1; enable = 1'b1; channel_linked = '1; out_ready = 1'b1;
    ready_mode = 1'b0; stall_chk = 1'b0;
    counter_th = 12'd4; idle_counter_number_th = 16'd1000;
    for (int i = 0; i < 8; i++) begin fill[i] = 0; head[i] = 0; pop_cnt[i] = 0; end
    drive_fifos();
    step(); step();
    reset = 1'b0;
    #1;
    clear_log();
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int b = 0;
    while (lg_data.size() < n && b < budget) begin step(); b++; end
    check({tag, "_words"}, lg_data.size(), n);
  endtask

  initial begin
    int exp_ch [8];
    int exp_k [8];

    // Reset values
    reset_dut();
    check("rst_valid", out_valid, 0);
    check("rst_first", out_first, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_channel", out_channel, 0);
    check("rst_busy", busy, 0);
    check("rst_read", channel_data_read, 0);

    // 1: threshold bursts of 4 from ch2, GAP between bursts
    counter_th = 12'd4; fill[2] = 10; drive_fifos(); #1;
    step();
    check("t1_busy_grant", busy, 1);
    check("t1_valid_grant", out_valid, 0);
    step();
    check("t1_valid_first", out_valid, 1);
    check("t1_first_flag", out_first, 1);
    check("t1_channel", out_channel, 2);
    check("t1_data0", out_data, word(2, 0));
    wait_words(8, 40, "t1");
    for (int k = 0; k < 8; k++) begin
      check("t1_data", lg_data[k], word(2, k));
      check("t1_first", lg_first[k], (k % 4) == 0);
      check("t1_last", lg_last[k], (k % 4) == 3);
      check("t1_ch", lg_ch[k], 2);
    end
    check("t1_gap", lg_cyc[4] - lg_cyc[3], 4);

    // 2: idle timeout grant on ch5
    reset_dut();
    counter_th = 12'd16; idle_counter_number_th = 16'd50; fill[5] = 3; drive_fifos(); #1;
    run(50);
    check("t2_no_early_grant", busy, 0);
    step();
    check("t2_timeout_grant", busy, 1);
    wait_words(3, 20, "t2");
    for (int k = 0; k < 3; k++) begin
      check("t2_data", lg_data[k], word(5, k));
      check("t2_first", lg_first[k], k == 0);
      check("t2_last", lg_last[k], k == 2);
    end
`ifdef SCHED_STATS_EN
    check("t2_stats_timeout", stats_timeout_grants[5*16 +: 16], 1);
    check("t2_stats_words", stats_words[5*32 +: 32], 3);
`endif

    // 3: round-robin order 0,3,7,0
    reset_dut();
    counter_th = 12'd2; fill[0] = 4; fill[3] = 4; fill[7] = 4; drive_fifos(); #1;
    exp_ch = '{0, 0, 3, 3, 7, 7, 0, 0};
    exp_k  = '{0, 1, 0, 1, 0, 1, 2, 3};
    wait_words(8, 80, "t3");
    for (int k = 0; k < 8; k++) begin
      check("t3_ch", lg_ch[k], exp_ch[k]);
      check("t3_data", lg_data[k], word(exp_ch[k], exp_k[k]));
      check("t3_first", lg_first[k], (k % 2) == 0);
    end

    // counter_th=0 acts as 1: single-word bursts
    reset_dut();
    counter_th = 12'd0; fill[4] = 2; drive_fifos(); #1;
    wait_words(2, 30, "th0");
    for (int k = 0; k < 2; k++) begin
      check("th0_data", lg_data[k], word(4, k));
      check("th0_first", lg_first[k], 1);
      check("th0_last", lg_last[k], 1);
    end

    // idle_th=0: any non-empty linked channel is eligible at once
    reset_dut();
    counter_th = 12'd16; idle_counter_number_th = 16'd0; fill[1] = 2; drive_fifos(); #1;
    step();
    check("idle0_busy", busy, 1);
    wait_words(2, 20, "idle0");
    check("idle0_last", lg_last[1], 1);

    // 4: 8-word burst with out_ready toggling
    reset_dut();
    counter_th = 12'd8; fill[1] = 8; ready_mode = 1'b1; stall_chk = 1'b1; drive_fifos(); #1;
    wait_words(8, 60, "t4");
    ready_mode = 1'b0; stall_chk = 1'b0; out_ready = 1'b1;
    run(5);
    check("t4_total_words", lg_data.size(), 8);
    check("t4_pops", pop_cnt[1], 8);
    for (int k = 0; k < 8; k++) check("t4_data", lg_data[k], word(1, k));
    check("t4_last", lg_last[7], 1);

    // 5: enable dropped during a 6-word burst
    reset_dut();
    counter_th = 12'd6; fill[6] = 12; drive_fifos(); #1;
    wait_words(2, 20, "t5a");
    enable = 1'b0; #1;
    wait_words(6, 40, "t5b");
    run(10);
    check("t5_total_words", lg_data.size(), 6);
    check("t5_last", lg_last[5], 1);
    check("t5_busy", busy, 0);
    check("t5_pops", pop_cnt[6], 6);

    // Link drop mid-burst: pending word closes the burst as last
    reset_dut();
    counter_th = 12'd8; fill[2] = 8; drive_fifos(); #1;
    wait_words(2, 20, "ld");
    channel_linked[2] = 1'b0; #1;
    run(10);
    check("ld_total_words", lg_data.size(), 3);
    check("ld_forced_last", lg_last[2], 1);
    check("ld_pops", pop_cnt[2], 3);
    check("ld_busy", busy, 0);

    // 6: reset mid-burst, then restart from ch0
    reset_dut();
    counter_th = 12'd8; fill[3] = 8; drive_fifos(); #1;
    wait_words(3, 20, "t6a");
    reset = 1'b1; #1;
    step();
    check("t6_valid", out_valid, 0);
    check("t6_first", out_first, 0);
    check("t6_last", out_last, 0);
    check("t6_data", out_data, 0);
    check("t6_channel", out_channel, 0);
    check("t6_busy", busy, 0);
    check("t6_read", channel_data_read, 0);
    counter_th = 12'd2; fill[0] = 2; fill[5] = 2; drive_fifos();
    reset = 1'b0; #1;
    clear_log();
    wait_words(1, 20, "t6b");
    check("t6_restart_ch", lg_ch[0], 0);
    check("t6_restart_data", lg_data[0], word(0, 0));

    check("no_pop_when_empty", bad_pop, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/readout_channel_scheduler.md
Name: readout_channel_scheduler

Overview:
- Sequences readout of up to NUM_CH TDS channel FIFOs, which are first-word-fall-through and 120-bit wide.
- Emits one burst per grant on a single 120-bit valid/ready stream to the Ethernet packet builder.
- Grants are round-robin among linked channels that have reached a fill threshold or an idle timeout.
- Sits between the channel_data_4 FIFOs and the MAC-side framing logic, all in the clk160 domain.

Parameters:
- NUM_CH, 8, number of channel FIFOs scheduled.
- CNT_W, 10, width of each channel_data_counter field.
- DATA_W, 120, FIFO word width.

Ports:
- clk  in  1  160 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allow new grants.
- channel_linked  in  NUM_CH  per-channel link-up.
- channel_fifo_empty  in  NUM_CH  per-channel FIFO empty.
- channel_data_counter  in  NUM_CH*CNT_W  fill counts; channel i occupies [i*CNT_W +: CNT_W].
- channel_data  in  NUM_CH*DATA_W  FWFT head words; channel i occupies [i*DATA_W +: DATA_W].
- channel_data_read  out  NUM_CH  one-cycle pop pulse per channel.
- counter_th  in  12  burst/fill threshold in words.
- idle_counter_number_th  in  16  idle timeout in cycles.
- out_data  out  DATA_W  output word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_first  out  1  first word of burst.
- out_last  out  1  last word of burst.
- out_channel  out  3  source channel of the current burst.
- busy  out  1  state is not IDLE.

Behaviour:
- Clocking and reset:
  - Single clock clk; reset is synchronous, active-high.
  - On reset: channel_data_read=0, out_valid=0, out_first=0, out_last=0, out_data=0, out_channel=0, busy=0.
  - Also on reset: rr pointer=0, all idle counters=0, state IDLE.
- Eligibility of channel i: linked[i] & !empty[i] & (count[i] >= th_eff | idle[i] >= idle_counter_number_th).
  - th_eff = max(counter_th, 1). counter_th is zero-extended against the 10-bit count.
  - idle_counter_number_th=0 makes any non-empty linked channel eligible immediately.
- Idle counter idle[i], 16 bits, saturating:
  - Increments each cycle that linked[i] & !empty[i] and i is not granted.
  - Clears when i is granted, when empty[i]=1, or when linked[i]=0.
- State machine:
  - IDLE: if enable and any channel eligible, go to GRANT.
  - GRANT (1 cycle):
    - Round-robin pick, first eligible channel searching upward from pointer (pointer wraps NUM_CH-1 to 0).
    - Latch out_channel.
    - Snapshot len = min(th_eff, count[ch]); a count of 0 sampled here is treated as 1, which is legal because !empty.
    - Pointer <= ch+1 mod NUM_CH. Go to BURST.
  - BURST:
    - Issue a pop when len_left>0 and the output register is empty or being accepted this cycle (out_valid & out_ready).
    - The pop pulses channel_data_read[ch] and registers channel_data[ch] into out_data with out_valid=1.
    - out_first=1 on the first word; out_last=1 when len_left==1. len_left decrements on each pop.
    - When the last word is accepted, go to GAP.
  - GAP (1 cycle): go to IDLE. This guarantees at least one idle cycle between bursts.
- Latency:
  - Eligibility to first out_valid: 2 cycles (IDLE to GRANT, GRANT to BURST pop).
  - Throughput is 1 word/cycle while out_ready=1.
- Handshake:
  - out_data, out_first, out_last and out_channel stay stable while out_valid & !out_ready.
  - Only this block pops the FIFOs, so the snapshot length guarantees no pop while empty. A pop is never issued when empty[ch]=1.
- Empty mid-burst (external s_reset): if empty[ch]=1 while len_left>0:
  - No further pops.
  - If no word is pending, emit nothing further. If a word is pending, it is forced out_last=1 and the burst ends.
  - A burst of zero length emits no words.
- Link drop mid-burst: same handling as empty mid-burst.
- enable deasserted mid-burst: the current burst completes; no new grant is made.
- Simultaneous eligibility: resolved by the rr pointer only; there is no fixed priority.
- Reset mid-burst: immediate return to reset values; the partial burst is abandoned with no out_last.
- Width rules: len and len_left are 12 bits; comparisons are unsigned.

Optional Feature:
- Macro: SCHED_STATS_EN.
- When defined, adds output stats_words, width NUM_CH*32.
  - One saturating 32-bit counter per channel, incremented on each accepted word from that channel. Cleared by reset.
- Also adds output stats_timeout_grants, width NUM_CH*16.
  - Saturating count of grants won by channels whose count < th_eff, i.e. timeout-only grants.
- When undefined: neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package readout_sched_pkg holds:
  - the state enum (IDLE, GRANT, BURST, GAP);
  - CNT_W, DATA_W, LEN_W=12, IDLE_W=16;
  - the channel-index width function.
- Sub-module rr_arbiter: NUM_CH request vector plus pointer in; one-hot grant and index out; purely combinational.

Test Plan:
1. counter_th=4, ch2 count=10 (others empty), out_ready=1 -> 4 words, from ch2 in FIFO order, with out_first on word 1 and out_last on word 4. A GAP cycle follows, then a second burst of 4.
2. counter_th=16, ch5 holds 3 words, idle_th=50 -> no grant before 50 idle cycles. Then a 3-word burst with out_last on word 3. stats_timeout_grants[5]=1 when SCHED_STATS_EN is defined.
3. ch0, ch3 and ch7 all eligible, counter_th=2 -> grant order 0,3,7,0; out_channel matches each burst.
4. out_ready toggling 1010 during an 8-word burst -> no word lost or duplicated; outputs held stable while stalled; exactly 8 pops.
5. enable dropped on word 2 of a 6-word burst -> all 6 words delivered, then IDLE with busy=0 and no further grants.
6. reset asserted on word 3 of a burst -> next cycle all outputs are 0 and the state is IDLE; after release, scheduling restarts from ch0.
